voq_xbar_ctrl: RTL and testbench

Virtual-output-queue bookkeeping and crossbar sequencing controller for the N x N, P-priority switch. It counts queued cells per (input, output, priority) and presents them as the scheduler's request vector. Each nonzero scheduler grant is turned into a crossbar configuration held for one cell time, with a dequeue pulse to the input buffers. Ports are reported idle to the scheduler only while not transferring.

---
 rtl/voq_xbar_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_voq_xbar_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voq_xbar_ctrl.sv
// voq_xbar_ctrl
//   VOQ bookkeeping and crossbar sequencing for an N x N, P-priority switch.
//   Keeps a CW-bit cell count per (input, priority, output) and presents the
//   nonzero set as the scheduler request vector. Accepted grants set up a
//   crossbar path for CELL_CYCLES cycles and issue a one-cycle dequeue pulse.
//
// Ports
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   i_arr_*           : cell arrival strobe and (input, output, priority)
//   o_sched_req       : bit j*N*P + k*N + i = VOQ(j, k, i) nonempty
//   o_input_idle      : per input, not transferring
//   o_output_idle     : per output, not owned
//   i_sched_grant     : bit j*N + i = input j matched to output i
//   i_sched_priority  : per input one-hot granted priority, field j at [j*P +: P]
//   o_xbar_en/_sel    : per output crossbar enable and selected input
//   o_deq*            : per input dequeue pulse with output and priority index
//   o_drop            : arrival lost (saturated VOQ or bad index)
//   o_grant_err       : at least one grant row rejected this cycle
module voq_xbar_ctrl #(
  parameter int N           = 12,
  parameter int P           = 8,
  parameter int IDX_W       = 4,
  parameter int PW          = 3,
  parameter int CW          = 4,
  parameter int CELL_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_arr_valid,
  input  logic [IDX_W-1:0]     i_arr_input,
  input  logic [IDX_W-1:0]     i_arr_output,
  input  logic [PW-1:0]        i_arr_pri,
  output logic [N*N*P-1:0]     o_sched_req,
  output logic [N-1:0]         o_input_idle,
  output logic [N-1:0]         o_output_idle,
  input  logic [N*N-1:0]       i_sched_grant,
  input  logic [N*P-1:0]       i_sched_priority,
  output logic [N-1:0]         o_xbar_en,
  output logic [N*IDX_W-1:0]   o_xbar_sel,
  output logic [N-1:0]         o_deq,
  output logic [N*IDX_W-1:0]   o_deq_output,
  output logic [N*PW-1:0]      o_deq_pri,
  output logic                 o_drop,
  output logic                 o_grant_err
);

  localparam int NC  = N * N * P;
  localparam int CIW = $clog2(NC);

  typedef enum logic {S_IDLE, S_XFER} state_e;

  logic [CW-1:0]    cnt_q     [NC];
  logic [CW-1:0]    cnt_d     [NC];
  state_e           state_q   [N];
  state_e           state_d   [N];
  logic [7:0]       timer_q   [N];
  logic [7:0]       timer_d   [N];
  logic [IDX_W-1:0] xout_q    [N];
  logic [IDX_W-1:0] xout_d    [N];
  logic [N-1:0]     own_v_q, own_v_d;
  logic [IDX_W-1:0] own_idx_q [N];
  logic [IDX_W-1:0] own_idx_d [N];
  logic [N-1:0]     deq_q, deq_d;
  logic [IDX_W-1:0] deq_out_q [N];
  logic [IDX_W-1:0] deq_out_d [N];
  logic [PW-1:0]    deq_pri_q [N];
  logic [PW-1:0]    deq_pri_d [N];
  logic             drop_q, drop_d;
  logic             gerr_q, gerr_d;

  // Grant decode results, one entry per input row
  logic [N-1:0]     col_multi;
  logic [N-1:0]     row_acc;
  logic [N-1:0]     row_bad;
  logic [IDX_W-1:0] row_out  [N];
  logic [PW-1:0]    row_pri  [N];
  logic [CIW-1:0]   row_cidx [N];
  logic [NC-1:0]    dec;

  // An output claimed by more than one row is a conflict for all of them,
  // including rows that would be rejected for other reasons.
  always_comb begin : col_check
    int unsigned hits;
    hits      = 0;
    col_multi = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hits = 0;
      for (int unsigned j = 0; j < N; j++) begin
        if (i_sched_grant[j*N + i]) hits = hits + 1;
      end
      col_multi[i] = (hits > 1);
    end
  end

  always_comb begin : row_decode
    logic [N-1:0]     row;
    logic [P-1:0]     pf;
    logic [IDX_W-1:0] oidx;
    logic [PW-1:0]    kidx;
    logic [CIW-1:0]   cidx;
    logic             held_other;
    logic             ok;
    row        = '0;
    pf         = '0;
    oidx       = '0;
    kidx       = '0;
    cidx       = '0;
    held_other = 1'b0;
    ok         = 1'b0;
    row_acc    = '0;
    row_bad    = '0;
    for (int unsigned j = 0; j < N; j++) begin
      row  = i_sched_grant[j*N +: N];
      pf   = i_sched_priority[j*P +: P];
      oidx = '0;
      kidx = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (row[i]) oidx = IDX_W'(i);
      end
      for (int unsigned k = 0; k < P; k++) begin
        if (pf[k]) kidx = PW'(k);
      end
      cidx        = CIW'(j*N*P + 32'(kidx)*N + 32'(oidx));
      row_out[j]  = oidx;
      row_pri[j]  = kidx;
      row_cidx[j] = cidx;
      held_other  = own_v_q[oidx] && (own_idx_q[oidx] != IDX_W'(j));
      ok = (state_q[j] == S_IDLE)
        && ((row & (row - 1'b1)) == '0)
        && (pf != '0) && ((pf & (pf - 1'b1)) == '0)
        && !held_other
        && (cnt_q[cidx] != '0)
        && !col_multi[oidx];
      if (row != '0) begin
        row_acc[j] = ok;
        row_bad[j] = !ok;
      end
    end
  end

  always_comb begin : next_state
    logic             arr_ok;
    logic [CIW-1:0]   aidx;
    logic             inc;
    arr_ok = i_arr_valid
          && (32'(i_arr_input)  < N)
          && (32'(i_arr_output) < N)
          && (32'(i_arr_pri)    < P);
    aidx   = CIW'(32'(i_arr_input)*N*P + 32'(i_arr_pri)*N + 32'(i_arr_output));
    inc    = 1'b0;

    cnt_d     = cnt_q;
    state_d   = state_q;
    timer_d   = timer_q;
    xout_d    = xout_q;
    own_v_d   = own_v_q;
    own_idx_d = own_idx_q;
    deq_d     = '0;
    drop_d    = i_arr_valid && !arr_ok;
    gerr_d    = |row_bad;
    dec       = '0;
    for (int unsigned j = 0; j < N; j++) begin
      deq_out_d[j] = '0;
      deq_pri_d[j] = '0;
    end

    // Transfer timers. A release only frees the output this input owns;
    // acceptance below reads registered ownership, so a freed output is
    // reusable one edge later.
    for (int unsigned j = 0; j < N; j++) begin
      if (state_q[j] == S_XFER) begin
        if (timer_q[j] == 8'd1) begin
          state_d[j]           = S_IDLE;
          own_v_d[xout_q[j]]   = 1'b0;
          own_idx_d[xout_q[j]] = '0;
        end else begin
          timer_d[j] = timer_q[j] - 8'd1;
        end
      end
    end

    for (int unsigned j = 0; j < N; j++) begin
      if (row_acc[j]) begin
        dec[row_cidx[j]]      = 1'b1;
        state_d[j]            = S_XFER;
        timer_d[j]            = 8'(CELL_CYCLES);
        xout_d[j]             = row_out[j];
        own_v_d[row_out[j]]   = 1'b1;
        own_idx_d[row_out[j]] = IDX_W'(j);
        deq_d[j]              = 1'b1;
        deq_out_d[j]          = row_out[j];
        deq_pri_d[j]          = row_pri[j];
      end
    end

    // Arrival and dequeue on the same VOQ cancel, so a saturated counter
    // does not drop in that case.
    for (int unsigned c = 0; c < NC; c++) begin
      inc = arr_ok && (CIW'(c) == aidx);
      if (inc && !dec[c]) begin
        if (cnt_q[c] == '1) drop_d = 1'b1;
        else                cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (dec[c] && !inc) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < NC; c++) cnt_q[c] <= '0;
      for (int unsigned j = 0; j < N; j++) begin
        state_q[j]   <= S_IDLE;
        timer_q[j]   <= '0;
        xout_q[j]    <= '0;
        own_idx_q[j] <= '0;
        deq_out_q[j] <= '0;
        deq_pri_q[j] <= '0;
      end
      own_v_q <= '0;
      deq_q   <= '0;
      drop_q  <= 1'b0;
      gerr_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      xout_q    <= xout_d;
      own_idx_q <= own_idx_d;
      deq_out_q <= deq_out_d;
      deq_pri_q <= deq_pri_d;
      own_v_q   <= own_v_d;
      deq_q     <= deq_d;
      drop_q    <= drop_d;
      gerr_q    <= gerr_d;
    end
  end

  always_comb begin : outputs
    o_sched_req   = '0;
    o_input_idle  = '0;
    o_xbar_sel    = '0;
    o_deq_output  = '0;
    o_deq_pri     = '0;
    for (int unsigned c = 0; c < NC; c++) o_sched_req[c] = |cnt_q[c];
    for (int unsigned j = 0; j < N; j++) begin
      o_input_idle[j]               = (state_q[j] == S_IDLE);
      o_xbar_sel[j*IDX_W +: IDX_W]  = own_idx_q[j];
      o_deq_output[j*IDX_W +: IDX_W] = deq_out_q[j];
      o_deq_pri[j*PW +: PW]         = deq_pri_q[j];
    end
  end

  assign o_output_idle = ~own_v_q;
  assign o_xbar_en     = own_v_q;
  assign o_deq         = deq_q;
  assign o_drop        = drop_q;
  assign o_grant_err   = gerr_q;

endmodule

// File: tb/tb_voq_xbar_ctrl.sv
module tb_voq_xbar_ctrl;

  localparam int N = 12;
  localparam int P = 8;
  localparam int IW = 4;
  localparam int PW = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Main instance (CELL_CYCLES = 8)
  logic             arr_valid;
  logic [IW-1:0]    arr_input, arr_output;
  logic [PW-1:0]    arr_pri;
  logic [N*N-1:0]   grant;
  logic [N*P-1:0]   gpri;
  logic [N*N*P-1:0] sched_req;
  logic [N-1:0]     input_idle, output_idle, xbar_en, deq;
  logic [N*IW-1:0]  xbar_sel, deq_output;
  logic [N*PW-1:0]  deq_pri;
  logic             drop, gerr;

  // Second instance (CELL_CYCLES = 1) for back-to-back timing
  logic             b_arr_valid;
  logic [IW-1:0]    b_arr_input, b_arr_output;
  logic [PW-1:0]    b_arr_pri;
  logic [N*N-1:0]   b_grant;
  logic [N*P-1:0]   b_gpri;
  logic [N*N*P-1:0] b_sched_req;
  logic [N-1:0]     b_input_idle, b_output_idle, b_xbar_en, b_deq;
  logic [N*IW-1:0]  b_xbar_sel, b_deq_output;
  logic [N*PW-1:0]  b_deq_pri;
  logic             b_drop, b_gerr;

  voq_xbar_ctrl #(.N(N), .P(P), .IDX_W(IW), .PW(PW), .CW(4), .CELL_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_arr_valid(arr_valid), .i_arr_input(arr_input), .i_arr_output(arr_output), .i_arr_pri(arr_pri),
    .o_sched_req(sched_req), .o_input_idle(input_idle), .o_output_idle(output_idle),
    .i_sched_grant(grant), .i_sched_priority(gpri),
    .o_xbar_en(xbar_en), .o_xbar_sel(xbar_sel),
    .o_deq(deq), .o_deq_output(deq_output), .o_deq_pri(deq_pri),
    .o_drop(drop), .o_grant_err(gerr));

  voq_xbar_ctrl #(.N(N), .P(P), .IDX_W(IW), .PW(PW), .CW(4), .CELL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_arr_valid(b_arr_valid), .i_arr_input(b_arr_input), .i_arr_output(b_arr_output), .i_arr_pri(b_arr_pri),
    .o_sched_req(b_sched_req), .o_input_idle(b_input_idle), .o_output_idle(b_output_idle),
    .i_sched_grant(b_grant), .i_sched_priority(b_gpri),
    .o_xbar_en(b_xbar_en), .o_xbar_sel(b_xbar_sel),
    .o_deq(b_deq), .o_deq_output(b_deq_output), .o_deq_pri(b_deq_pri),
    .o_drop(b_drop), .o_grant_err(b_gerr));

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct { int j; int o; int k; } deq_t;
  deq_t sbq[$];

  typedef struct {
    logic [IW-1:0] inp;
    logic [IW-1:0] outp;
    logic [PW-1:0] pri;
    logic          exp_drop;
    logic          in_range;
  } arr_vec_t;
  arr_vec_t vt[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int rb(input int j, input int k, input int i);
    return j*N*P + k*N + i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input int j, input int i, input int k);
    arr_input  = IW'(j);
    arr_output = IW'(i);
    arr_pri    = PW'(k);
    arr_valid  = 1'b1;
    tick();
    arr_valid  = 1'b0;
  endtask

  task automatic set_grant(input int j, input int i, input int k, input bit expect_acc);
    grant[j*N + i] = 1'b1;
    gpri[j*P + k]  = 1'b1;
    if (expect_acc) sbq.push_back('{j: j, o: i, k: k});
  endtask

  task automatic clr_grant();
    grant = '0;
    gpri  = '0;
  endtask

  task automatic wait_idle(input int j);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (input_idle[j]) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) begin
      total_cnt++;
      $display("FAIL wait_idle: input %0d still busy after 30 cycles, required idle", j);
    end
  endtask

  // Dequeue scoreboard: every o_deq pulse must match the oldest expected grant
  always @(negedge clk) begin
    if (!reset) begin
      for (int j = 0; j < N; j++) begin
        if (deq[j]) begin
          if (sbq.size() == 0) begin
            total_cnt++;
            $display("FAIL deq_unexpected: got o_deq[%0d]=1 required 0", j);
          end else begin
            deq_t e;
            e = sbq.pop_front();
            chk("deq_input", 64'(j), 64'(e.j));
            chk("deq_output", 64'(deq_output[j*IW +: IW]), 64'(e.o));
            chk("deq_pri", 64'(deq_pri[j*PW +: PW]), 64'(e.k));
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    int drops;
    int acc;

    vt[0] = '{inp: 4'd2,  outp: 4'd5,  pri: 3'd3, exp_drop: 1'b0, in_range: 1'b1};
    vt[1] = '{inp: 4'd2,  outp: 4'd5,  pri: 3'd3, exp_drop: 1'b0, in_range: 1'b1};
    vt[2] = '{inp: 4'd12, outp: 4'd0,  pri: 3'd0, exp_drop: 1'b1, in_range: 1'b0};
    vt[3] = '{inp: 4'd0,  outp: 4'd12, pri: 3'd0, exp_drop: 1'b1, in_range: 1'b0};
    vt[4] = '{inp: 4'd15, outp: 4'd15, pri: 3'd7, exp_drop: 1'b1, in_range: 1'b0};
    vt[5] = '{inp: 4'd0,  outp: 4'd0,  pri: 3'd0, exp_drop: 1'b0, in_range: 1'b1};
    vt[6] = '{inp: 4'd11, outp: 4'd11, pri: 3'd7, exp_drop: 1'b0, in_range: 1'b1};
    vt[7] = '{inp: 4'd0,  outp: 4'd1,  pri: 3'd0, exp_drop: 1'b0, in_range: 1'b1};

    arr_valid = 1'b0; arr_input = '0; arr_output = '0; arr_pri = '0;
    grant = '0; gpri = '0;
    b_arr_valid = 1'b0; b_arr_input = '0; b_arr_output = '0; b_arr_pri = '0;
    b_grant = '0; b_gpri = '0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #2;
    chk("rst_req", 64'(|sched_req), 64'd0);
    chk("rst_in_idle", 64'(input_idle), 64'hFFF);
    chk("rst_out_idle", 64'(output_idle), 64'hFFF);
    chk("rst_xbar_en", 64'(xbar_en), 64'd0);
    chk("rst_xbar_sel", 64'(xbar_sel), 64'd0);
    chk("rst_deq", 64'(deq), 64'd0);
    chk("rst_drop_gerr", 64'({drop, gerr}), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Table-driven arrivals: drop flag and request bit
    for (int v = 0; v < 8; v++) begin
      arr_input  = vt[v].inp;
      arr_output = vt[v].outp;
      arr_pri    = vt[v].pri;
      arr_valid  = 1'b1;
      tick();
      arr_valid  = 1'b0;
      chk($sformatf("arr_drop_%0d", v), 64'(drop), 64'(vt[v].exp_drop));
      if (vt[v].in_range)
        chk($sformatf("arr_req_%0d", v),
            64'(sched_req[rb(int'(vt[v].inp), int'(vt[v].pri), int'(vt[v].outp))]), 64'd1);
    end

    // Grant 2->5 priority 3; counter 2 -> 1
    set_grant(2, 5, 3, 1'b1);
    tick();
    clr_grant();
    chk("g25_xbar_sel", 64'(xbar_sel[5*IW +: IW]), 64'd2);
    chk("g25_in_idle", 64'(input_idle[2]), 64'd0);
    chk("g25_out_idle", 64'(output_idle[5]), 64'd0);
    chk("g25_gerr", 64'(gerr), 64'd0);
    chk("g25_req_kept", 64'(sched_req[rb(2, 3, 5)]), 64'd1);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (xbar_en[5]) cnt++;
      tick();
    end
    chk("g25_hold_cycles", 64'(cnt), 64'd8);
    chk("g25_idle_back", 64'({input_idle[2], output_idle[5]}), 64'd3);

    // Grant while input busy, and grant to an empty VOQ
    set_grant(0, 0, 0, 1'b1);
    tick();
    clr_grant();
    set_grant(0, 1, 0, 1'b0);
    tick();
    clr_grant();
    chk("busy_gerr", 64'(gerr), 64'd1);
    chk("busy_no_path", 64'(xbar_en[1]), 64'd0);
    chk("busy_req_kept", 64'(sched_req[rb(0, 0, 1)]), 64'd1);
    tick();
    chk("gerr_pulse_end", 64'(gerr), 64'd0);
    set_grant(5, 6, 2, 1'b0);
    tick();
    clr_grant();
    chk("empty_gerr", 64'(gerr), 64'd1);
    chk("empty_in_idle", 64'(input_idle[5]), 64'd1);
    chk("empty_req", 64'(sched_req[rb(5, 2, 6)]), 64'd0);
    repeat (10) tick();

    // Output conflict (1->7, 4->7) alongside a valid 3->0
    arrive(1, 7, 0);
    arrive(4, 7, 0);
    arrive(3, 0, 0);
    set_grant(1, 7, 0, 1'b0);
    set_grant(4, 7, 0, 1'b0);
    set_grant(3, 0, 0, 1'b1);
    tick();
    clr_grant();
    chk("conf_gerr", 64'(gerr), 64'd1);
    chk("conf_out7_en", 64'(xbar_en[7]), 64'd0);
    chk("conf_out0_en", 64'(xbar_en[0]), 64'd1);
    chk("conf_out0_sel", 64'(xbar_sel[0 +: IW]), 64'd3);
    chk("conf_req_1", 64'(sched_req[rb(1, 0, 7)]), 64'd1);
    chk("conf_req_4", 64'(sched_req[rb(4, 0, 7)]), 64'd1);
    repeat (10) tick();

    // Saturation of VOQ (6, pri 1, out 9)
    drops = 0;
    for (int a = 0; a < 15; a++) begin
      arrive(6, 9, 1);
      if (drop) drops++;
    end
    chk("sat_no_drop", 64'(drops), 64'd0);
    arrive(6, 9, 1);
    chk("sat_drop", 64'(drop), 64'd1);
    arr_input = 4'd6; arr_output = 4'd9; arr_pri = 3'd1; arr_valid = 1'b1;
    set_grant(6, 9, 1, 1'b1);
    tick();
    arr_valid = 1'b0;
    clr_grant();
    chk("sat_same_cycle_drop", 64'(drop), 64'd0);
    chk("sat_same_cycle_busy", 64'(input_idle[6]), 64'd0);
    // Drain: the number of accepted grants gives the count left behind
    acc = 0;
    wait_idle(6);
    for (int it = 0; it < 20; it++) begin
      if (!sched_req[rb(6, 1, 9)]) break;
      set_grant(6, 9, 1, 1'b1);
      tick();
      clr_grant();
      acc++;
      wait_idle(6);
    end
    chk("sat_drain_count", 64'(acc), 64'd15);

    // Reset in the middle of a transfer
    arrive(8, 2, 4);
    set_grant(8, 2, 4, 1'b1);
    tick();
    clr_grant();
    chk("mid_xfer_en", 64'(xbar_en[2]), 64'd1);
    tick();
    chk("mid_req_nonzero", 64'(|sched_req), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 64'(|sched_req), 64'd0);
    chk("mid_rst_in_idle", 64'(input_idle), 64'hFFF);
    chk("mid_rst_out_idle", 64'(output_idle), 64'hFFF);
    chk("mid_rst_xbar", 64'({xbar_en, xbar_sel}), 64'd0);
    tick();
    reset = 1'b0;

    // Back-to-back grants with CELL_CYCLES = 1
    b_arr_input = 4'd2; b_arr_output = 4'd3; b_arr_pri = 3'd1; b_arr_valid = 1'b1;
    repeat (3) tick();
    b_arr_valid = 1'b0;
    b_grant[2*N + 3] = 1'b1;
    b_gpri[2*P + 1]  = 1'b1;
    tick();
    chk("b2b_first_deq", 64'(b_deq[2]), 64'd1);
    chk("b2b_first_out", 64'(b_deq_output[2*IW +: IW]), 64'd3);
    chk("b2b_first_pri", 64'(b_deq_pri[2*PW +: PW]), 64'd1);
    chk("b2b_first_en", 64'(b_xbar_en[3]), 64'd1);
    tick();
    chk("b2b_second_deq", 64'(b_deq[2]), 64'd0);
    chk("b2b_second_gerr", 64'(b_gerr), 64'd1);
    tick();
    b_grant = '0;
    b_gpri  = '0;
    chk("b2b_third_deq", 64'(b_deq[2]), 64'd1);
    chk("b2b_third_gerr", 64'(b_gerr), 64'd0);
    tick();
    chk("b2b_release", 64'({b_xbar_en[3], b_input_idle[2]}), 64'd1);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
